ltpi_uart_slot_scheduler: RTL
=============================

// Module: ltpi_uart_slot_scheduler
// PURPOSE
// Shares the single UART byte slot of each outgoing LTPI frame between NUM_CH UART channel samplers.
// Sits between per-channel UART byte sources and the LTPI frame builder.
// On every frame-slot request it grants one pending channel by round-robin, hands its byte to the
// builder with a channel ID, and flags channels starved for too many consecutive frames.
// PARAMETERS
// NUM_CH      4    number of UART requesters (2..16)
// STARVE_LIM  8    frame slots a pending channel may be skipped before starve_flag sets (1..255)
// CH_ID_W     $clog2(NUM_CH)  channel ID width (derived, not overridable)
// PORTS
// clk          in   1           block clock
// reset_n      in   1           asynchronous active-low reset
// ch_valid     in   NUM_CH      channel i has a byte pending
// ch_data      in   NUM_CH*8    channel i byte at [8*i+:8]
// ch_ready     out  NUM_CH      one-hot, 1-cycle consume strobe to the granted channel
// slot_req     in   1           1-cycle pulse from the frame builder: UART slot open
// slot_valid   out  1           slot_ch_id/slot_data valid; held until slot_ack
// slot_ch_id   out  CH_ID_W     granted channel
// slot_data    out  8           granted byte
// slot_empty   out  1           1-cycle pulse: slot_req served with no channel pending
// slot_ack     in   1           builder has taken slot_data
// slot_miss    out  1           sticky: slot_req arrived while in ARB/HOLD
// starve_flag  out  NUM_CH      sticky per-channel starvation flag
// flag_clr     in   1           clears slot_miss and all starve_flag bits
// BEHAVIOUR
// - Reset: all outputs 0, rr_ptr=0, FSM=IDLE, starve counters 0. Reset mid-operation drops the held byte;
//   it was already consumed from its channel and is lost by design.
// - FSM states are IDLE, ARB and HOLD.
//   - IDLE: on slot_req go to ARB.
//   - ARB (1 cycle): g = first i with ch_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_CH.
//     - If a channel is found: ch_ready[g]=1 this cycle, latch ch_data[g] and g, go to HOLD.
//     - If none is found: slot_empty=1 this cycle, go to IDLE.
//   - HOLD: slot_valid=1 with stable ch_id/data until slot_ack.
//     - On slot_ack: slot_valid drops next cycle and rr_ptr = (g+1) mod NUM_CH.
//     - Then go to IDLE; if slot_req is in the same cycle as slot_ack, go straight to ARB.
// - Latency: slot_req in cycle N gives ch_ready in N+1 and slot_valid high from N+2.
// - slot_req in ARB, or in HOLD without slot_ack: the request is ignored and slot_miss sets.
// - slot_ack outside HOLD is ignored.
// - Starvation is evaluated in each ARB cycle:
//   - A channel with ch_valid=1 and not granted increments its counter, saturating at STARVE_LIM.
//   - A channel that is granted or has ch_valid=0 clears its counter.
//   - starve_flag[i] sets when counter[i] reaches STARVE_LIM.
// - flag_clr wins over a simultaneous set for slot_miss. It does not win for starve_flag:
//   the counters are not reset, so the flag re-sets at the next ARB if the counter is still at the limit.
// - ch_ready is never asserted for a channel whose ch_valid=0 in that cycle.
// STRUCTURE
// - ltpi_uart_pkg holds: FSM state enum (IDLE/ARB/HOLD), UART_BYTE_W=8, and the NUM_CH/STARVE_LIM range checks.
// - Sub-module ltpi_rr_arbiter (NUM_CH): inputs req vector and rr_ptr; outputs one-hot grant, grant index, any_grant.
//   It is purely combinational. The scheduler owns rr_ptr, the FSM, the holding register and the starve counters.
// TESTING
// - ch_valid=4'b0101, data 0x11/0x33, 2 slot_req each acked -> ch0 0x11, then ch2 0x33; rr_ptr=3.
// - ch_valid=0, slot_req -> slot_empty pulse, no ch_ready, slot_valid stays 0.
// - slot_ack held low for 5 cycles, slot_req pulsed in HOLD -> data stable, slot_miss=1; flag_clr -> 0.
// - ch0 and ch1 always valid, STARVE_LIM=2 -> strict alternation, no starve_flag.
//   Repeat with ch1 ch_valid only during HOLD -> starve_flag[1]=0.
// - slot_ack and slot_req in the same cycle -> ARB next cycle, ch_ready for the next rr channel.
// - reset_n low while in HOLD -> slot_valid=0 and ch_ready=0 immediately; after release the next slot grants from ch0.

Source files
------------

// File: rtl/ltpi_uart_pkg.sv
// Shared types and limits for the LTPI UART slot scheduler.
package ltpi_uart_pkg;

  localparam int unsigned UART_BYTE_W    = 8;
  localparam int unsigned STARVE_CNT_W   = 8;
  localparam int unsigned NUM_CH_MIN     = 2;
  localparam int unsigned NUM_CH_MAX     = 16;
  localparam int unsigned STARVE_LIM_MIN = 1;
  localparam int unsigned STARVE_LIM_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

  // True when the scheduler parameters are inside their supported ranges.
  function automatic logic cfg_ok(input int unsigned num_ch, input int unsigned starve_lim);
    return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
           (starve_lim >= STARVE_LIM_MIN) && (starve_lim <= STARVE_LIM_MAX);
  endfunction

endpackage

// File: rtl/ltpi_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, wrapping.
module ltpi_rr_arbiter #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  rr_ptr_i,
  output logic [NUM_CH-1:0] grant_oh_c,
  output logic [IDX_W-1:0]  grant_idx_c,
  output logic              any_grant_c
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_oh_c  = '0;
    grant_idx_c = '0;
    any_grant_c = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(rr_ptr_i) + k) % NUM_CH;
      if (!any_grant_c && req_i[IDX_W'(idx)]) begin
        any_grant_c = 1'b1;
        grant_idx_c = IDX_W'(idx);
      end
    end
    if (any_grant_c) grant_oh_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/ltpi_uart_slot_scheduler.sv
// Grants the per-frame UART byte slot to one of NUM_CH channels by round-robin,
// holds the byte for the frame builder and tracks per-channel starvation.
module ltpi_uart_slot_scheduler
  import ltpi_uart_pkg::*;
#(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned STARVE_LIM = 8,
  localparam int unsigned CH_ID_W    = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*UART_BYTE_W-1:0] ch_data,
  output logic [NUM_CH-1:0]             ch_ready,
  input  logic                          slot_req,
  output logic                          slot_valid,
  output logic [CH_ID_W-1:0]            slot_ch_id,
  output logic [UART_BYTE_W-1:0]        slot_data,
  output logic                          slot_empty,
  input  logic                          slot_ack,
  output logic                          slot_miss,
  output logic [NUM_CH-1:0]             starve_flag,
  input  logic                          flag_clr
);

  if (!cfg_ok(NUM_CH, STARVE_LIM)) begin : g_cfg_err
    $error("ltpi_uart_slot_scheduler: NUM_CH or STARVE_LIM out of range");
  end

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIM);

  sched_state_e              state_q, state_d;
  logic [CH_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CH_ID_W-1:0]        hold_id_q, hold_id_d;
  logic [UART_BYTE_W-1:0]    hold_data_q, hold_data_d;
  logic                      slot_miss_q, slot_miss_d;
  logic                      miss_set;
  logic [NUM_CH-1:0]         starve_flag_q, starve_flag_d, starve_set;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q [NUM_CH];
  logic [STARVE_CNT_W-1:0]   starve_cnt_d [NUM_CH];

  logic [NUM_CH-1:0]         gnt_oh;
  logic [CH_ID_W-1:0]        gnt_idx;
  logic                      any_gnt;
  logic [UART_BYTE_W-1:0]    gnt_byte;

  ltpi_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i       (ch_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_oh_c  (gnt_oh),
    .grant_idx_c (gnt_idx),
    .any_grant_c (any_gnt)
  );

  // Byte of the channel the arbiter picked.
  always_comb begin
    gnt_byte = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_ID_W'(i)) gnt_byte = ch_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      hold_id_q     <= '0;
      hold_data_q   <= '0;
      slot_miss_q   <= 1'b0;
      starve_flag_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) starve_cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_id_q     <= hold_id_d;
      hold_data_q   <= hold_data_d;
      slot_miss_q   <= slot_miss_d;
      starve_flag_q <= starve_flag_d;
      for (int unsigned i = 0; i < NUM_CH; i++) starve_cnt_q[i] <= starve_cnt_d[i];
    end
  end

  // Slot FSM; ch_ready and slot_empty are combinational strobes of the ARB cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_id_d   = hold_id_q;
    hold_data_d = hold_data_q;
    ch_ready    = '0;
    slot_empty  = 1'b0;
    miss_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        miss_set = slot_req;
        if (any_gnt) begin
          ch_ready    = gnt_oh;
          hold_id_d   = gnt_idx;
          hold_data_d = gnt_byte;
          state_d     = ST_HOLD;
        end else begin
          slot_empty = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (slot_ack) begin
          rr_ptr_d = (hold_id_q == CH_ID_W'(NUM_CH - 1)) ? '0 : hold_id_q + CH_ID_W'(1);
          state_d  = slot_req ? ST_ARB : ST_IDLE;
        end else begin
          miss_set = slot_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation counters advance only in ARB; a set beats a same-cycle flag_clr.
  always_comb begin
    starve_set = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      starve_cnt_d[i] = starve_cnt_q[i];
      if (state_q == ST_ARB) begin
        if (ch_valid[i] && !gnt_oh[i]) begin
          starve_cnt_d[i] = (starve_cnt_q[i] >= LIM) ? LIM : starve_cnt_q[i] + STARVE_CNT_W'(1);
        end else begin
          starve_cnt_d[i] = '0;
        end
        starve_set[i] = (starve_cnt_d[i] == LIM);
      end
    end
    starve_flag_d = (starve_flag_q & ~{NUM_CH{flag_clr}}) | starve_set;
    slot_miss_d   = flag_clr ? 1'b0 : (slot_miss_q | miss_set);
  end

  assign slot_valid  = (state_q == ST_HOLD);
  assign slot_ch_id  = hold_id_q;
  assign slot_data   = hold_data_q;
  assign slot_miss   = slot_miss_q;
  assign starve_flag = starve_flag_q;

endmodule
